alu_flags_unit: RTL and testbench

ALU_FLAGS_UNIT -- requirements
Module: alu_flags_unit

---
 rtl/alu_flags_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_flags_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flags_unit.sv
// alu_flags_unit: single-stage registered ALU with condition flags, optional
// signed saturation, sticky overflow flag and saturating overflow counter.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   CNT_W      width of the overflow event counter
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation accepted when high together with in_valid
//   a, b       signed two's-complement operands
//   seleccion  [2:0] opcode, [3] saturate enable
//   out_valid  result/flags valid
//   out_ready  consumer accepts the current result
//   result     registered result
//   n, z, c, v registered negative / zero / carry / overflow flags
//   clr_sticky clear sticky_v and ovf_count
//   sticky_v   an overflow has been accepted since the last clear
//   ovf_count  number of accepted overflowing operations (saturating)
module alu_flags_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       seleccion,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  input  logic             clr_sticky,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAdc  = 3'b010,
    OpSbc  = 3'b011,
    OpNeg  = 3'b100,
    OpCmp  = 3'b101,
    OpPass = 3'b110
  } op_e;

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // State
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath
  op_e              opcode;
  logic             sat_en;
  logic [WIDTH:0]   op_x, op_y;
  logic             cin;
  logic [WIDTH:0]   raw;
  logic             raw_msb;
  logic             a_msb, b_msb;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             ovf_event;

  assign opcode = op_e'(seleccion[2:0]);
  assign sat_en = seleccion[3];
  assign a_msb  = a[WIDTH-1];
  assign b_msb  = b[WIDTH-1];

  // Every arithmetic op is expressed as x + y + cin over WIDTH+1 bits so the
  // carry out falls out of the top bit; subtraction is x + ~y + 1 (carry set
  // means no borrow).
  always_comb begin
    op_x = {1'b0, a};
    op_y = {1'b0, b};
    cin  = 1'b0;
    case (opcode)
      OpAdd: begin
        op_y = {1'b0, b};
        cin  = 1'b0;
      end
      OpSub, OpCmp: begin
        op_y = {1'b0, ~b};
        cin  = 1'b1;
      end
      OpAdc: begin
        op_y = {1'b0, b};
        cin  = c_q;
      end
      OpSbc: begin
        op_y = {1'b0, ~b};
        cin  = c_q;
      end
      OpNeg: begin
        op_x = '0;
        op_y = {1'b0, ~a};
        cin  = 1'b1;
      end
      default: begin
        // PASS: a + 0 with no carry in
        op_y = '0;
        cin  = 1'b0;
      end
    endcase
  end

  assign raw     = op_x + op_y + {{WIDTH{1'b0}}, cin};
  assign raw_msb = raw[WIDTH-1];

  // Flags from the unclamped sum
  always_comb begin
    alu_c = raw[WIDTH];
    alu_v = 1'b0;
    case (opcode)
      OpAdd, OpAdc:        alu_v = (a_msb == b_msb) && (raw_msb != a_msb);
      OpSub, OpSbc, OpCmp: alu_v = (a_msb != b_msb) && (raw_msb != a_msb);
      OpNeg:               alu_v = (a == MinNeg);
      default: begin
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  // Saturation: a set raw MSB on overflow means the true value went past the
  // positive limit, a clear one means it went past the negative limit.
  always_comb begin
    alu_res = raw[WIDTH-1:0];
    if (sat_en && alu_v) begin
      alu_res = raw_msb ? MaxPos : MinNeg;
    end
  end

  // Handshake
  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign ovf_event = accept & alu_v;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      n_d         = alu_res[WIDTH-1];
      z_d         = (alu_res == '0);
      c_d         = alu_c;
      v_d         = alu_v;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky flag and counter: a new overflow wins over a same-cycle clear, so
  // the event is never lost.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_sticky) begin
      sticky_d = ovf_event;
      cnt_d    = ovf_event ? CNT_W'(1) : '0;
    end else if (ovf_event) begin
      sticky_d = 1'b1;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign n         = n_q;
  assign z         = z_q;
  assign c         = c_q;
  assign v         = v_q;
  assign sticky_v  = sticky_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed bench for alu_flags_unit (WIDTH=4, CNT_W=8).
module tb_alu_flags_unit;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       seleccion;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             z;
  logic             c;
  logic             v;
  logic             clr_sticky;
  logic             sticky_v;
  logic [CNT_W-1:0] ovf_count;

  int passed;
  int total;

  alu_flags_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .seleccion  (seleccion),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .n          (n),
    .z          (z),
    .c          (c),
    .v          (v),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op at the falling edge, let the rising edge take it, then
  // sample 1 time unit after that edge.
  task automatic do_op(input logic [3:0] s, input logic [WIDTH-1:0] aa,
                       input logic [WIDTH-1:0] bb, input logic clr);
    @(negedge clk);
    seleccion  = s;
    a          = aa;
    b          = bb;
    clr_sticky = clr;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] res, input logic en,
                         input logic ez, input logic ec, input logic ev);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".result"}, result, res);
    chk({tag, ".n"}, n, en);
    chk({tag, ".z"}, z, ez);
    chk({tag, ".c"}, c, ec);
    chk({tag, ".v"}, v, ev);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    seleccion  = '0;
    clr_sticky = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 4'h0);
    chk("rst.nzcv", {n, z, c, v}, 4'b0000);
    chk("rst.sticky", sticky_v, 1'b0);
    chk("rst.count", ovf_count, 8'd0);
    chk("rst.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow, unsaturated then saturated
    do_op(4'b0000, 4'b0111, 4'b0001, 1'b0);
    chk_out("add_ovf", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("add_ovf.sticky", sticky_v, 1'b1);
    chk("add_ovf.count", ovf_count, 8'd1);
    do_op(4'b1000, 4'b0111, 4'b0001, 1'b0);
    chk_out("add_sat", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("add_sat.count", ovf_count, 8'd2);

    // Carry chain: ADD sets c, ADC consumes it, SUB borrows
    do_op(4'b0000, 4'b1111, 4'b0001, 1'b0);
    chk_out("add_carry", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(4'b0010, 4'b0000, 4'b0000, 1'b0);
    chk_out("adc", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'b0001, 4'b0000, 4'b0001, 1'b0);
    chk_out("sub_borrow", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

    // NEG
    do_op(4'b0100, 4'b1000, 4'b0000, 1'b0);
    chk_out("neg_min", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("neg_min.count", ovf_count, 8'd3);
    do_op(4'b0100, 4'b0011, 4'b0000, 1'b0);
    chk_out("neg3", 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);

    // SBC with c=0: 5 - 3 - 1 = 1, no borrow
    do_op(4'b0011, 4'b0101, 4'b0011, 1'b0);
    chk_out("sbc", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    // CMP 2 - 5 = -3
    do_op(4'b0101, 4'b0010, 4'b0101, 1'b0);
    chk_out("cmp", 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    // PASS clears carry
    do_op(4'b0110, 4'b1010, 4'b0011, 1'b0);
    chk_out("pass", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    // Saturated SUB negative overflow: -8 - 1 clamps to -8
    do_op(4'b1001, 4'b1000, 4'b0001, 1'b0);
    chk_out("sub_sat", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("sub_sat.count", ovf_count, 8'd4);

    // Backpressure: op X accepted, op Y stalls while out_ready=0
    do_op(4'b0000, 4'b0001, 4'b0001, 1'b0);
    chk("bp.x_result", result, 4'b0010);
    out_ready = 1'b0;
    a         = 4'b0011;
    b         = 4'b0001;
    in_valid  = 1'b1;
    #1;
    chk("bp.in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("bp.held_result", result, 4'b0010);
    chk("bp.held_valid", out_valid, 1'b1);
    chk("bp.held_in_ready", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.y_result", result, 4'b0100);
    chk("bp.y_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    chk("bp.drained", out_valid, 1'b0);

    // Clear coinciding with an overflow keeps the event
    do_op(4'b0000, 4'b0111, 4'b0001, 1'b1);
    chk("clr_ovf.sticky", sticky_v, 1'b1);
    chk("clr_ovf.count", ovf_count, 8'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("clr.sticky", sticky_v, 1'b0);
    chk("clr.count", ovf_count, 8'd0);

    // 300 back-to-back overflows saturate the counter
    @(negedge clk);
    seleccion = 4'b0000;
    a         = 4'b0111;
    b         = 4'b0001;
    in_valid  = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("cnt_sat.count", ovf_count, 8'd255);
    chk("cnt_sat.sticky", sticky_v, 1'b1);

    // Reset mid-stream while a result is held
    do_op(4'b0000, 4'b1111, 4'b0001, 1'b0);
    out_ready = 1'b0;
    chk("pre_rst.valid", out_valid, 1'b1);
    chk("pre_rst.c", c, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", out_valid, 1'b0);
    chk("mid_rst.result", result, 4'h0);
    chk("mid_rst.nzcv", {n, z, c, v}, 4'b0000);
    chk("mid_rst.sticky", sticky_v, 1'b0);
    chk("mid_rst.count", ovf_count, 8'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    do_op(4'b0010, 4'b0000, 4'b0000, 1'b0);
    chk_out("post_rst_adc", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
